alu_issue: RTL and testbench

Execute-stage issuer driving the 3-bit-op ALU in the RV32 core. Accepts one decoded instruction per handshake, selects operands, drives the ALU for one cycle, and converts the ALU result/flags into a register-writeback value or a branch decision. Sits between the decode/register-read stage and writeback; the ALU is instantiated beside it and connected point-to-point.

---
 rtl/alu_pkg.sv | 77 +++++++
 rtl/alu_issue_if.sv | 62 ++++++
 rtl/alu_issue_decode.sv | 88 ++++++++
 rtl/alu_issue.sv | 194 +++++++++++++++++++
 tb/tb_alu_issue.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the execute-stage issuer (alu_issue) and its decoder:
//   - alu_op_e   : 3-bit ALU operation encodings driven on alu_op
//   - OPC_*      : RV32 major opcodes handled by the issuer
//   - state_e    : issuer FSM states
//   - a_sel_e / b_sel_e : operand source selects produced by the decoder
//   - res_kind_e : how the ALU result/flags turn into writeback or branch
//   - branch_cond(): funct3-indexed branch resolution from ALU flags
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_XOR = 3'b011,
        ALU_AND = 3'b100,
        ALU_SRA = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLL = 3'b111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        A_ZERO,
        A_RS1,
        A_PC
    } a_sel_e;

    typedef enum logic [1:0] {
        B_ZERO,
        B_RS2,
        B_IMM
    } b_sel_e;

    typedef enum logic [2:0] {
        RK_ALU,
        RK_SLT,
        RK_SLTU,
        RK_BRANCH,
        RK_ILLEGAL
    } res_kind_e;

    // Branch outcome from the flags of a SUB of rs1 - rs2. Encodings 010/011
    // are rejected by the decoder and never reach here as a branch.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       u_slt,
                                         input logic       s_slt);
        logic taken;
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;     // BEQ
            3'b001:  taken = !zero;    // BNE
            3'b100:  taken = s_slt;    // BLT
            3'b101:  taken = !s_slt;   // BGE
            3'b110:  taken = u_slt;    // BLTU
            3'b111:  taken = !u_slt;   // BGEU
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// ----------------------------------------------------------------------------
// alu_issue_if
// Bundles every non-clock signal of the execute-stage issuer:
//   upstream   : in_valid, in_ready, opcode, funct3, funct7b5,
//                rs1_val, rs2_val, imm, pc
//   ALU side   : alu_a, alu_b, alu_op (to ALU); alu_result, alu_zero,
//                alu_u_slt, alu_s_slt (from ALU)
//   downstream : out_valid, out_ready, rd_data, rd_we, br_taken,
//                br_target, illegal
// Modports:
//   slave  - the issuer (alu_issue): consumes instructions and ALU results,
//            produces ALU operands and writeback/branch results
//   master - the surroundings: decode stage, ALU and writeback
// ----------------------------------------------------------------------------
interface alu_issue_if;
    import alu_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_e     alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_u_slt;
    logic        alu_s_slt;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd_data;
    logic        rd_we;
    logic        br_taken;
    logic [31:0] br_target;
    logic        illegal;

    modport slave (
        input  in_valid, opcode, funct3, funct7b5, rs1_val, rs2_val, imm, pc,
        output in_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero, alu_u_slt, alu_s_slt,
        output out_valid, rd_data, rd_we, br_taken, br_target, illegal,
        input  out_ready
    );

    modport master (
        output in_valid, opcode, funct3, funct7b5, rs1_val, rs2_val, imm, pc,
        input  in_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero, alu_u_slt, alu_s_slt,
        input  out_valid, rd_data, rd_we, br_taken, br_target, illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_issue_decode.sv
// ----------------------------------------------------------------------------
// alu_decode
// Combinational decode of a registered RV32 opcode/funct into:
//   alu_op     - ALU operation
//   a_sel      - alu_a source (zero / rs1 / pc)
//   b_sel      - alu_b source (zero / rs2 / imm)
//   shamt_only - alu_b is reduced to the low 5 bits (shift amount)
//   kind       - how the result is consumed (ALU, SLT, SLTU, BRANCH, ILLEGAL)
// Inputs: opcode[6:0], funct3[2:0], funct7b5.
// Configuration macro: ALU_ISSUE_BRANCH_EN enables BRANCH decode; without it
// BRANCH decodes as illegal.
// ----------------------------------------------------------------------------
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output alu_op_e    alu_op,
    output a_sel_e     a_sel,
    output b_sel_e     b_sel,
    output logic       shamt_only,
    output res_kind_e  kind
);

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned (which would infer a latch).
    always_comb begin
        alu_op     = ALU_ADD;
        a_sel      = A_ZERO;
        b_sel      = B_ZERO;
        shamt_only = 1'b0;
        kind       = RK_ILLEGAL;

        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                a_sel = A_RS1;
                b_sel = (opcode == OPC_OP) ? B_RS2 : B_IMM;
                kind  = RK_ALU;
                case (funct3)
                    // funct7b5 on ADDI is just an immediate bit, so only
                    // the register form can select SUB.
                    3'b000: alu_op = (opcode == OPC_OP && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        alu_op     = ALU_SLL;
                        shamt_only = 1'b1;
                    end
                    3'b010: begin
                        alu_op = ALU_SUB;
                        kind   = RK_SLT;
                    end
                    3'b011: begin
                        alu_op = ALU_SUB;
                        kind   = RK_SLTU;
                    end
                    3'b100: alu_op = ALU_XOR;
                    3'b101: begin
                        alu_op     = funct7b5 ? ALU_SRA : ALU_SRL;
                        shamt_only = 1'b1;
                    end
                    3'b110: alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OPC_LUI: begin
                b_sel = B_IMM;
                kind  = RK_ALU;
            end
            OPC_AUIPC: begin
                a_sel = A_PC;
                b_sel = B_IMM;
                kind  = RK_ALU;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            OPC_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    a_sel  = A_RS1;
                    b_sel  = B_RS2;
                    alu_op = ALU_SUB;
                    kind   = RK_BRANCH;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ----------------------------------------------------------------------------
// alu_issue
// Execute-stage issuer for the RV32 core. Accepts one decoded instruction per
// handshake, drives the neighbouring ALU for one cycle from registered
// operands, and turns the ALU result/flags into a writeback value or a branch
// decision. One instruction every three cycles: IDLE (accept), EXEC (ALU),
// DONE (hold result until out_ready).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - alu_issue_if.slave: upstream handshake + operands, ALU operand
//           and result lines, downstream handshake + results
// Configuration macro: ALU_ISSUE_BRANCH_EN enables branch resolution
// (br_taken, br_target); without it branches are illegal and both branch
// outputs stay 0.
// ----------------------------------------------------------------------------
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu_issue_if.slave  bus
);

    state_e      state;

    // Captured instruction; the ALU is fed only from these.
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [31:0] pc_q;

    // Registered handshake and result outputs.
    logic        in_ready_q;
    logic        out_valid_q;
    logic [31:0] rd_data_q;
    logic        rd_we_q;
    logic        br_taken_q;
    logic [31:0] br_target_q;
    logic        illegal_q;

    alu_op_e     dec_op;
    a_sel_e      a_sel;
    b_sel_e      b_sel;
    logic        shamt_only;
    res_kind_e   kind;

    logic [31:0] a_val;
    logic [31:0] b_raw;
    logic [31:0] b_val;

    logic [31:0] rd_data_d;
    logic        rd_we_d;
    logic        br_taken_d;
    logic [31:0] br_target_d;
    logic        illegal_d;

    alu_decode u_decode (
        .opcode     (opcode_q),
        .funct3     (funct3_q),
        .funct7b5   (funct7b5_q),
        .alu_op     (dec_op),
        .a_sel      (a_sel),
        .b_sel      (b_sel),
        .shamt_only (shamt_only),
        .kind       (kind)
    );

    // Operand select from the captured instruction.
    always_comb begin
        a_val = '0;
        b_raw = '0;
        case (a_sel)
            A_RS1:   a_val = rs1_q;
            A_PC:    a_val = pc_q;
            default: a_val = '0;
        endcase
        case (b_sel)
            B_RS2:   b_raw = rs2_q;
            B_IMM:   b_raw = imm_q;
            default: b_raw = '0;
        endcase
        b_val = shamt_only ? {27'b0, b_raw[4:0]} : b_raw;
    end

    assign bus.alu_a  = a_val;
    assign bus.alu_b  = b_val;
    assign bus.alu_op = dec_op;

    // Result formation from the ALU outputs present during EXEC.
    always_comb begin
        rd_data_d   = '0;
        rd_we_d     = 1'b0;
        br_taken_d  = 1'b0;
        br_target_d = '0;
        illegal_d   = 1'b0;
        case (kind)
            RK_ALU: begin
                rd_data_d = bus.alu_result;
                rd_we_d   = 1'b1;
            end
            RK_SLT: begin
                rd_data_d = {31'b0, bus.alu_s_slt};
                rd_we_d   = 1'b1;
            end
            RK_SLTU: begin
                rd_data_d = {31'b0, bus.alu_u_slt};
                rd_we_d   = 1'b1;
            end
`ifdef ALU_ISSUE_BRANCH_EN
            RK_BRANCH: begin
                br_taken_d  = branch_cond(funct3_q, bus.alu_zero,
                                          bus.alu_u_slt, bus.alu_s_slt);
                // Target adder is local so the ALU stays free for the compare.
                br_target_d = pc_q + imm_q;
            end
`endif
            default: illegal_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7b5_q  <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        opcode_q   <= bus.opcode;
                        funct3_q   <= bus.funct3;
                        funct7b5_q <= bus.funct7b5;
                        rs1_q      <= bus.rs1_val;
                        rs2_q      <= bus.rs2_val;
                        imm_q      <= bus.imm;
                        pc_q       <= bus.pc;
                        in_ready_q <= 1'b0;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rd_data_q   <= rd_data_d;
                    rd_we_q     <= rd_we_d;
                    br_taken_q  <= br_taken_d;
                    br_target_q <= br_target_d;
                    illegal_q   <= illegal_d;
                    out_valid_q <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    // Return to IDLE first; a new instruction is only taken
                    // on a later edge.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_we     = rd_we_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.br_target = br_target_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// ----------------------------------------------------------------------------
// tb_alu_issue
// Directed testbench for alu_issue. Provides a behavioural ALU on the
// interface, issues hand-computed instruction vectors and compares outputs.
// Branch expectations follow ALU_ISSUE_BRANCH_EN as built.
// ----------------------------------------------------------------------------
module tb_alu_issue;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU connected point-to-point.
    logic [31:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (bus.alu_op)
            ALU_ADD: alu_r = bus.alu_a + bus.alu_b;
            ALU_SUB: alu_r = bus.alu_a - bus.alu_b;
            ALU_OR:  alu_r = bus.alu_a | bus.alu_b;
            ALU_XOR: alu_r = bus.alu_a ^ bus.alu_b;
            ALU_AND: alu_r = bus.alu_a & bus.alu_b;
            ALU_SRA: alu_r = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            ALU_SRL: alu_r = bus.alu_a >> bus.alu_b[4:0];
            ALU_SLL: alu_r = bus.alu_a << bus.alu_b[4:0];
            default: alu_r = '0;
        endcase
        bus.alu_result = alu_r;
        bus.alu_zero   = (alu_r == 32'd0);
        bus.alu_u_slt  = (bus.alu_a < bus.alu_b);
        bus.alu_s_slt  = ($signed(bus.alu_a) < $signed(bus.alu_b));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one instruction at a negedge; returns just after the accept edge.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] i, input logic [31:0] p);
        @(negedge clk);
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.rs1_val  = a;
        bus.rs2_val  = b;
        bus.imm      = i;
        bus.pc       = p;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = 7'b0000000;
        bus.funct3   = 3'b111;
        bus.funct7b5 = 1'b1;
        bus.rs1_val  = 32'hDEAD_BEEF;
        bus.rs2_val  = 32'h0BAD_F00D;
        bus.imm      = 32'h1234_5677;
        bus.pc       = 32'hCAFE_0000;
    endtask

    // Cycle index (in_valid cycle = 0) at which out_valid is seen; bounded.
    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Complete the DONE handshake (out_ready assumed high).
    task automatic finish_out();
        @(posedge clk);
        #1;
    endtask

    task automatic exec_alu(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                            input logic f7, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] i, input logic [31:0] p,
                            input logic [31:0] exp_rd);
        int lat;
        send(opc, f3, f7, a, b, i, p);
        wait_out(lat);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_rd"}, bus.rd_data, exp_rd);
        check({tag, "_we"}, {31'b0, bus.rd_we}, 32'd1);
        check({tag, "_ill"}, {31'b0, bus.illegal}, 32'd0);
        finish_out();
    endtask

    // Branch or illegal: no writeback; checks taken/target/illegal.
    task automatic exec_nowb(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] i, input logic [31:0] p,
                             input logic exp_taken, input logic [31:0] exp_tgt,
                             input logic exp_ill);
        int lat;
        send(opc, f3, 1'b0, a, b, i, p);
        wait_out(lat);
        check({tag, "_lat"}, lat, 32'd2);
        check({tag, "_we"}, {31'b0, bus.rd_we}, 32'd0);
        check({tag, "_taken"}, {31'b0, bus.br_taken}, {31'b0, exp_taken});
        check({tag, "_tgt"}, bus.br_target, exp_tgt);
        check({tag, "_ill"}, {31'b0, bus.illegal}, {31'b0, exp_ill});
        if (exp_ill) check({tag, "_rd"}, bus.rd_data, 32'd0);
        finish_out();
    endtask

    initial begin
        int  lat;
        bit  seen;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode   = '0;
        bus.funct3   = '0;
        bus.funct7b5 = 1'b0;
        bus.rs1_val  = '0;
        bus.rs2_val  = '0;
        bus.imm      = '0;
        bus.pc       = '0;

        #12;
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_rd_we", {31'b0, bus.rd_we}, 32'd0);
        check("rst_br_taken", {31'b0, bus.br_taken}, 32'd0);
        check("rst_br_target", bus.br_target, 32'd0);
        check("rst_illegal", {31'b0, bus.illegal}, 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        check("rst_alu_b", bus.alu_b, 32'd0);
        check("rst_alu_op", {29'b0, bus.alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Arithmetic / logic vectors.
        exec_alu("add",   OPC_OP,    3'b000, 1'b0, 32'd5,  32'd7,  32'd0, 32'd0, 32'd12);
        exec_alu("sub",   OPC_OP,    3'b000, 1'b1, 32'd10, 32'd3,  32'd0, 32'd0, 32'd7);
        exec_alu("addi",  OPC_OPIMM, 3'b000, 1'b1, 32'd10, 32'd99, 32'd3, 32'd0, 32'd13);
        exec_alu("slt",   OPC_OP,    3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1);
        exec_alu("sltu",  OPC_OP,    3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0);
        exec_alu("sra",   OPC_OP,    3'b101, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'hF800_0000);
        exec_alu("srl",   OPC_OP,    3'b101, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'h0800_0000);
        exec_alu("xori",  OPC_OPIMM, 3'b100, 1'b0, 32'h0000_F0F0, 32'd0, 32'h0000_00FF, 32'd0, 32'h0000_F00F);
        exec_alu("and",   OPC_OP,    3'b111, 1'b0, 32'h0000_FF00, 32'h0000_0FF0, 32'd0, 32'd0, 32'h0000_0F00);
        exec_alu("or",    OPC_OP,    3'b110, 1'b0, 32'h0000_FF00, 32'h0000_0FF0, 32'd0, 32'd0, 32'h0000_FFF0);
        exec_alu("lui",   OPC_LUI,   3'b000, 1'b0, 32'h55, 32'h66, 32'h1234_5000, 32'h40, 32'h1234_5000);
        exec_alu("auipc", OPC_AUIPC, 3'b000, 1'b0, 32'h55, 32'h66, 32'h0000_2000, 32'h1000, 32'h0000_3000);

        // SLLI with an out-of-range immediate: only the low 5 bits shift.
        send(OPC_OPIMM, 3'b001, 1'b0, 32'd1, 32'd0, 32'h21, 32'd0);
        check("slli_alu_b", bus.alu_b, 32'd1);
        check("slli_alu_a", bus.alu_a, 32'd1);
        check("slli_alu_op", {29'b0, bus.alu_op}, {29'b0, ALU_SLL});
        wait_out(lat);
        check("slli_lat", lat, 32'd2);
        check("slli_rd", bus.rd_data, 32'd2);
        finish_out();

        // Branches.
`ifdef ALU_ISSUE_BRANCH_EN
        exec_nowb("bne",  OPC_BRANCH, 3'b001, 32'd3, 32'd3, 32'h20, 32'h100, 1'b0, 32'h120, 1'b0);
        exec_nowb("beq",  OPC_BRANCH, 3'b000, 32'd3, 32'd3, 32'h20, 32'h100, 1'b1, 32'h120, 1'b0);
        exec_nowb("blt",  OPC_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 1'b1, 32'h10, 1'b0);
        exec_nowb("bgeu", OPC_BRANCH, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h8, 32'h200, 1'b0, 32'h208, 1'b0);
`else
        exec_nowb("bne",  OPC_BRANCH, 3'b001, 32'd3, 32'd3, 32'h20, 32'h100, 1'b0, 32'd0, 1'b1);
        exec_nowb("blt",  OPC_BRANCH, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b1);
`endif
        exec_nowb("br010", OPC_BRANCH, 3'b010, 32'd3, 32'd4, 32'h20, 32'h100, 1'b0, 32'd0, 1'b1);
        exec_nowb("load",  7'b0000011, 3'b010, 32'd3, 32'd4, 32'h20, 32'h100, 1'b0, 32'd0, 1'b1);

        // Backpressure: result held, in_ready low, new in_valid ignored.
        bus.out_ready = 1'b0;
        send(OPC_OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0);
        wait_out(lat);
        check("bp_lat", lat, 32'd2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.opcode   = OPC_OP;
            bus.funct3   = 3'b000;
            bus.funct7b5 = 1'b0;
            bus.rs1_val  = 32'd9;
            bus.rs2_val  = 32'd9;
            bus.in_valid = 1'b1;
            check("bp_rd", bus.rd_data, 32'd2);
            check("bp_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);
        check("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("bp_no_same_cycle_accept", {31'b0, seen}, 32'd0);
        check("bp_rd_kept", bus.rd_data, 32'd2);

        // Reset during EXEC drops the instruction.
        send(OPC_OP, 3'b000, 1'b0, 32'd4, 32'd4, 32'd0, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_exec_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_exec_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_exec_rd", bus.rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        check("rst_exec_dropped", {31'b0, seen}, 32'd0);
        check("rst_exec_in_ready", {31'b0, bus.in_ready}, 32'd1);

        exec_alu("recover", OPC_OP, 3'b000, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 32'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
